// File: rtl/uart_tx_serializer_if.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer_if
//   Byte-in / serial-out bundle for the UART transmit serializer.
//   master : byte source (drives tx_data / tx_valid, observes everything else)
//   slave  : the serializer (accepts bytes, drives the line and status flags)
// Signals
//   tx_data   [DATA_BITS]  byte to send, sampled on accept
//   tx_valid               tx_data valid
//   tx_ready               serializer can accept; accept = tx_valid & tx_ready
//   tx_serial              serial line, idle high
//   tx_busy                high from accept edge until frame ends
//   tx_done                one-clk pulse when the last stop bit completes
// -----------------------------------------------------------------------------
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_serial;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_serial,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_serial,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//   UART transmit side of the Lab4 serial link. Accepts a parallel byte over a
//   valid/ready handshake and shifts it out as
//       start(0) + data (LSB first) + [parity] + stop(1) x STOP_BITS
//   on tx_serial. Bit timing comes from sample_tick, the shared 16x oversample
//   enable that also paces the receiver, so both ends use one baud generator.
//
// Build option
//   UART_TX_PARITY_EN : when defined, a parity bit (even, or odd when
//                       PARITY_ODD=1) is sent after the data bits. When not
//                       defined there is no parity bit and PARITY_ODD is
//                       ignored.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9)
//   OVERSAMPLE  sample_tick pulses per serial bit (power of 2, 2..16)
//   STOP_BITS   stop bits per frame (1 or 2)
//   PARITY_ODD  0 = even parity, 1 = odd parity
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset; aborts any frame
//   sample_tick  in   one-clk enable at OVERSAMPLE x baud rate
//   tx           slave modport of uart_tx_serializer_if (byte in, line out)
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    uart_tx_serializer_if.slave  tx
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int IDX_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
    // Stop-bit index of the final stop bit: 0 for one stop bit, 1 for two.
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    // Reject configurations the counters are not sized for.
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_serializer: DATA_BITS must be 5..9");
    end
    if (OVERSAMPLE < 2 || OVERSAMPLE > 16 ||
        (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
        $error("uart_tx_serializer: OVERSAMPLE must be a power of 2 in 2..16");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [TICK_W-1:0]    tick_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift_reg;

    logic                 serial_r;
    logic                 ready_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 accept;
    logic                 bit_end;

`ifdef UART_TX_PARITY_EN
    logic                 par_bit;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY_ODD != 0) ? ~(^d) : (^d);
    endfunction
`endif

    // ready_r is only ever high in IDLE, the state check keeps the intent obvious.
    assign accept  = (state == S_IDLE) && ready_r && tx.tx_valid;
    // A serial bit ends on the tick that wraps the oversample counter.
    assign bit_end = sample_tick && (tick_cnt == TICK_LAST);

    assign tx.tx_serial = serial_r;
    assign tx.tx_ready  = ready_r;
    assign tx.tx_busy   = busy_r;
    assign tx.tx_done   = done_r;

    // ---- control: FSM, counters and registered outputs ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            serial_r <= 1'b1;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;

            // The oversample counter runs only inside a frame; it is back at
            // zero whenever IDLE is entered because the last bit ends on a wrap.
            if (state != S_IDLE && sample_tick) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    serial_r <= 1'b1;
                    if (accept) begin
                        state    <= S_START;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        tick_cnt <= '0;
                        serial_r <= 1'b0;
                        ready_r  <= 1'b0;
                        busy_r   <= 1'b1;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        state    <= S_DATA;
                        serial_r <= shift_reg[0];
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state    <= S_PARITY;
                            serial_r <= par_bit;
`else
                            state    <= S_STOP;
                            serial_r <= 1'b1;
`endif
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            // shift_reg shifts on this same edge, so the next
                            // data bit is the one currently at position 1.
                            serial_r <= shift_reg[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state    <= S_STOP;
                        serial_r <= 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (bit_end) begin
                        if (stop_idx == STOP_LAST) begin
                            // Frame complete: handshake reopens on this edge,
                            // so the earliest next accept is the following one.
                            state    <= S_IDLE;
                            stop_idx <= 1'b0;
                            done_r   <= 1'b1;
                            busy_r   <= 1'b0;
                            ready_r  <= 1'b1;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    serial_r <= 1'b1;
                    ready_r  <= 1'b1;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    // ---- data: shift register and latched parity, no reset needed ----
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_reg <= tx.tx_data;
        end else if (state == S_DATA && bit_end) begin
            shift_reg <= shift_reg >> 1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (accept) begin
            par_bit <= parity_of(tx.tx_data);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//   Directed bench for uart_tx_serializer (DATA_BITS=8, OVERSAMPLE=16,
//   STOP_BITS=1, PARITY_ODD=0). Expected frames are written out by hand as
//   {stop, [parity], data, start}, time order from bit 0 upward.
//   Define UART_TX_PARITY_EN for both RTL and bench to exercise parity frames.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic clk;
    logic reset;
    logic sample_tick;

    uart_tx_serializer_if #(.DATA_BITS(8)) u_if ();

    uart_tx_serializer #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .STOP_BITS  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .tx          (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [7:0]  data;
        int          div;
        logic [11:0] frame;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Frame for a byte whose expected parity bit (if any) is 0.
    function automatic logic [11:0] mk_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b0, 1'b1, 1'b0, d, 1'b0};
`else
        return {2'b00, 1'b1, d, 1'b0};
`endif
    endfunction

    // Sends one byte and follows the whole frame clock by clock. sample_tick
    // fires on every div-th edge after the accept edge, so a bit lasts 16*div
    // clocks and the frame exactly NBITS*16*div clocks. The line is checked at
    // the first and last clock of every bit; done/ready/busy at the end.
    task automatic run_frame(input logic [7:0] d, input int div, input logic [11:0] exp,
                             input string nm, input bit skip_setup,
                             input bit hold_valid, input logic [7:0] next_d);
        int t;
        int f;
        int k;
        int b;
        bit early;
        t = 16 * div;
        f = NBITS * t;
        early = 1'b0;
        if (!skip_setup) begin
            @(negedge clk);
            u_if.tx_data  = d;
            u_if.tx_valid = 1'b1;
            sample_tick   = 1'b0;
        end
        @(posedge clk);
        for (int c = 1; c <= f + 1; c++) begin
            @(negedge clk);
            k = c - 1;
            if (c == 1) begin
                check({nm, " busy_after_accept"}, u_if.tx_busy, 1);
                check({nm, " ready_after_accept"}, u_if.tx_ready, 0);
                u_if.tx_valid = hold_valid;
                if (hold_valid) u_if.tx_data = next_d;
            end
            if (k < f) begin
                b = k / t;
                if ((k % t) == 0 || (k % t) == t - 1)
                    check($sformatf("%s line bit%0d clk%0d", nm, b, k), u_if.tx_serial, exp[b]);
                if (u_if.tx_done) early = 1'b1;
            end else begin
                check({nm, " done_at_end"}, u_if.tx_done, 1);
                check({nm, " ready_at_end"}, u_if.tx_ready, 1);
                check({nm, " busy_at_end"}, u_if.tx_busy, 0);
                check({nm, " line_idle_at_end"}, u_if.tx_serial, 1);
                check({nm, " no_early_done"}, early, 0);
            end
            sample_tick = ((c % div) == 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   seen_done;
        bit   line_low;
        vec_t v;

        vecs.push_back('{8'hA5, 1, mk_frame(8'hA5), "a5_tick1"});   // 0,1,0,1,0,0,1,0,1,(p0),1
        vecs.push_back('{8'h00, 3, mk_frame(8'h00), "00_tick3"});
        vecs.push_back('{8'h5A, 2, mk_frame(8'h5A), "5a_tick2"});
        vecs.push_back('{8'hE7, 4, mk_frame(8'hE7), "e7_tick4"});
`ifdef UART_TX_PARITY_EN
        vecs.push_back('{8'h07, 1, 12'b0_1_1_00000111_0, "07_parity1"});
        vecs.push_back('{8'h03, 1, 12'b0_1_0_00000011_0, "03_parity0"});
`endif

        // Reset held three clocks with the tick running.
        reset         = 1'b1;
        sample_tick   = 1'b1;
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset line", u_if.tx_serial, 1);
        check("reset ready", u_if.tx_ready, 1);
        check("reset busy", u_if.tx_busy, 0);
        check("reset done", u_if.tx_done, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle line with ticks", u_if.tx_serial, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            run_frame(v.data, v.div, v.frame, v.name, 1'b0, 1'b0, 8'h00);
            @(negedge clk);
            check({v.name, " done_one_clk"}, u_if.tx_done, 0);
        end

        // Back-to-back: valid held, data changed while busy, second byte must
        // start exactly one idle clock after the first frame ends.
        run_frame(8'h3C, 1, mk_frame(8'h3C), "b2b_first", 1'b0, 1'b1, 8'hC3);
        run_frame(8'hC3, 1, mk_frame(8'hC3), "b2b_second", 1'b1, 1'b0, 8'h00);
        @(negedge clk);

        // Reset during data bit 4 of 8'hFF (clocks 80..95 after accept).
        @(negedge clk);
        u_if.tx_data  = 8'hFF;
        u_if.tx_valid = 1'b1;
        sample_tick   = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 86; c++) begin
            @(negedge clk);
            if (c == 1) u_if.tx_valid = 1'b0;
            if (c == 86) begin
                check("abort pre line", u_if.tx_serial, 1);
                check("abort pre busy", u_if.tx_busy, 1);
                reset = 1'b1;
            end
            sample_tick = 1'b1;
        end
        @(negedge clk);
        check("abort line", u_if.tx_serial, 1);
        check("abort ready", u_if.tx_ready, 1);
        check("abort busy", u_if.tx_busy, 0);
        check("abort done", u_if.tx_done, 0);
        reset     = 1'b0;
        seen_done = 1'b0;
        line_low  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (u_if.tx_done) seen_done = 1'b1;
            if (!u_if.tx_serial) line_low = 1'b1;
        end
        check("abort no done pulse", seen_done, 0);
        check("abort line stays idle", line_low, 0);
        run_frame(8'h81, 1, mk_frame(8'h81), "after_abort_81", 1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
